pwm_generator: RTL



---
 rtl/pwm_pkg.sv | 18 +
 rtl/pwm_prescaler.sv | 20 ++
 rtl/pwm_generator.sv | 61 ++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared defaults and the slew helper for the PWM generator.
package pwm_pkg;
  localparam int DEF_DUTY_W  = 8;
  localparam int DEF_PRESC_W = 16;
  localparam int CNT_MAX     = (1 << DEF_DUTY_W) - 2;
  localparam logic [DEF_DUTY_W-1:0] DUTY_RESET = '1;

  // Moves current toward target by at most step; step <= 0 means jump straight there.
  // Evaluated in int so the difference never wraps for any duty width used here.
  function automatic int sat_step(int target, int current, int step);
    int diff;
    diff = target - current;
    if (step <= 0)     return target;
    if (diff > step)   return current + step;
    if (diff < -step)  return current - step;
    return target;
  endfunction
endpackage

// File: rtl/pwm_prescaler.sv
// Tick generator: one tick every div+1 clocks, held off while clear is high.
module pwm_prescaler #(
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic [PRESC_W-1:0] div,
  output logic               tick
);
  logic [PRESC_W-1:0] presc_cnt;

  assign tick = !clear && (presc_cnt == div);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)            presc_cnt <= '0;
    else if (clear || tick)  presc_cnt <= '0;
    else                     presc_cnt <= presc_cnt + 1'b1;
  end
endmodule

// File: rtl/pwm_generator.sv
// Double-buffered PWM with optional per-period duty slew and a period-wrap strobe.
module pwm_generator import pwm_pkg::*; #(
  parameter int DUTY_W   = DEF_DUTY_W,
  parameter int PRESC_W  = DEF_PRESC_W,
  parameter int MAX_STEP = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [DUTY_W-1:0]  duty_in,
  input  logic [PRESC_W-1:0] prescale_div,
  input  logic               enable,
  input  logic               invert,
  output logic               pwm_out,
  output logic               period_end,
  output logic [DUTY_W-1:0]  duty_active
);
  // Period is 2^DUTY_W-1 ticks so a full-scale duty stays high through the wrap.
  localparam logic [DUTY_W-1:0] LAST_CNT = DUTY_W'((1 << DUTY_W) - 2);

  logic [DUTY_W-1:0]  cnt, duty_q, duty_next;
  logic [PRESC_W-1:0] div_shadow;
  logic               tick, wrap, raw;

  pwm_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (!enable),
    .div     (div_shadow),
    .tick    (tick)
  );

  assign wrap        = tick && (cnt == LAST_CNT);
  assign raw         = cnt < duty_q;
  assign duty_next   = DUTY_W'(sat_step(32'(duty_in), 32'(duty_q), MAX_STEP));
  assign duty_active = duty_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= '0;
      duty_q     <= '1;
      div_shadow <= '0;
      pwm_out    <= 1'b0;
      period_end <= 1'b0;
    end else begin
      pwm_out    <= enable ? (raw ^ invert) : invert;
      period_end <= wrap;
      if (!enable) begin
        // Idle tracks the inputs directly so the first period starts from fresh shadows.
        cnt        <= '0;
        duty_q     <= duty_in;
        div_shadow <= prescale_div;
      end else if (wrap) begin
        cnt        <= '0;
        duty_q     <= duty_next;
        div_shadow <= prescale_div;
      end else if (tick) begin
        cnt        <= cnt + 1'b1;
      end
    end
  end
endmodule
